// File: rtl/pippo_redirect_pkg.sv
// Shared definitions for the pippo redirect controller: state encodings,
// counter width and default redirect vectors.
package pippo_redirect_pkg;

  localparam int unsigned REDIR_CNT_W = 3;
  localparam int unsigned REDIR_ADDR_W = 32;

  localparam logic [REDIR_ADDR_W-1:0] REDIR_RST_VECTOR   = 32'h0000_0000;
  localparam logic [REDIR_ADDR_W-1:0] REDIR_ALIGN_VECTOR = 32'h0000_0010;

  typedef enum logic [1:0] {
    REDIR_IDLE  = 2'd0,
    REDIR_FLUSH = 2'd1,
    REDIR_REQ   = 2'd2
  } redir_state_e;

endpackage

// File: rtl/pippo_redirect_pend.sv
// Single-entry pending-exception slot: a write overwrites any older entry,
// a consume empties it.
module pippo_redirect_pend
  import pippo_redirect_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [REDIR_ADDR_W-1:0] wr_vector,
  input  logic                    consume,
  output logic                    valid,
  output logic [REDIR_ADDR_W-1:0] vector
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      vector <= '0;
    end else if (wr) begin
      valid  <= 1'b1;
      vector <= wr_vector;
    end else if (consume) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/pippo_redirect_ctrl.sv
// Redirect sequencer: captures branch/exception redirects, runs a timed
// flush, then hands the new fetch address over a valid/ack handshake.
// Optional misaligned-branch check: define PIPPO_REDIRECT_ALIGN_CHK_EN.
module pippo_redirect_ctrl
  import pippo_redirect_pkg::*;
#(
  parameter int unsigned                FLUSH_CYCLES = 1,
  parameter logic [REDIR_ADDR_W-1:0]    RST_VECTOR   = REDIR_RST_VECTOR,
  parameter logic [REDIR_ADDR_W-1:0]    ALIGN_VECTOR = REDIR_ALIGN_VECTOR
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    npc_branch_valid,
  input  logic [REDIR_ADDR_W-1:0] npc_branch,
  input  logic                    except_valid,
  input  logic [REDIR_ADDR_W-1:0] except_vector,
  input  logic                    npc_ack,
  output logic                    flush_pipe,
  output logic                    stall_exe,
  output logic                    npc_valid,
  output logic [REDIR_ADDR_W-1:0] npc,
  output logic                    redirect_is_exc,
  output logic                    align_fault
);

`ifdef PIPPO_REDIRECT_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  localparam logic [REDIR_CNT_W-1:0] CNT_LOAD = REDIR_CNT_W'(FLUSH_CYCLES);
  localparam logic [REDIR_CNT_W-1:0] CNT_ONE  = REDIR_CNT_W'(1);

  redir_state_e            state;
  logic [REDIR_CNT_W-1:0]  cnt;
  logic [REDIR_ADDR_W-1:0] target;
  logic                    pend_valid;
  logic [REDIR_ADDR_W-1:0] pend_vector;
  logic                    pend_wr;
  logic                    pend_consume;
  logic                    misaligned;

  // Exceptions seen in REQ without an ack wait in the slot; the ack drains it.
  assign pend_wr      = (state == REDIR_REQ) && except_valid && !npc_ack;
  assign pend_consume = (state == REDIR_REQ) && npc_ack;
  assign misaligned   = ALIGN_CHK && (npc_branch[1:0] != 2'b00);

  pippo_redirect_pend u_pend (
    .clk       (clk),
    .rst       (rst),
    .wr        (pend_wr),
    .wr_vector (except_vector),
    .consume   (pend_consume),
    .valid     (pend_valid),
    .vector    (pend_vector)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= REDIR_IDLE;
      cnt             <= '0;
      target          <= RST_VECTOR;
      flush_pipe      <= 1'b0;
      stall_exe       <= 1'b0;
      npc_valid       <= 1'b0;
      npc             <= '0;
      redirect_is_exc <= 1'b0;
      align_fault     <= 1'b0;
    end else begin
      align_fault <= 1'b0;
      case (state)
        REDIR_IDLE: begin
          if (except_valid || npc_branch_valid) begin
            state      <= REDIR_FLUSH;
            cnt        <= CNT_LOAD;
            flush_pipe <= 1'b1;
            stall_exe  <= 1'b1;
          end
          if (except_valid) begin
            target          <= except_vector;
            redirect_is_exc <= 1'b1;
          end else if (npc_branch_valid) begin
            if (misaligned) begin
              target          <= ALIGN_VECTOR;
              redirect_is_exc <= 1'b1;
              align_fault     <= 1'b1;
            end else begin
              target          <= npc_branch;
              redirect_is_exc <= 1'b0;
            end
          end
        end

        REDIR_FLUSH: begin
          // A late exception retargets and restarts the flush window.
          if (except_valid) begin
            target          <= except_vector;
            redirect_is_exc <= 1'b1;
            cnt             <= CNT_LOAD;
          end else if (cnt <= CNT_ONE) begin
            state      <= REDIR_REQ;
            flush_pipe <= 1'b0;
            npc_valid  <= 1'b1;
            npc        <= target;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        REDIR_REQ: begin
          if (npc_ack) begin
            npc_valid <= 1'b0;
            if (except_valid || pend_valid) begin
              state           <= REDIR_FLUSH;
              cnt             <= CNT_LOAD;
              flush_pipe      <= 1'b1;
              redirect_is_exc <= 1'b1;
              target          <= except_valid ? except_vector : pend_vector;
            end else begin
              state     <= REDIR_IDLE;
              stall_exe <= 1'b0;
            end
          end
        end

        default: begin
          state      <= REDIR_IDLE;
          flush_pipe <= 1'b0;
          stall_exe  <= 1'b0;
          npc_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pippo_redirect_ctrl.sv
// Directed bench for pippo_redirect_ctrl: expected redirects are queued when
// a request is driven and compared when npc_valid rises.
module tb_pippo_redirect_ctrl;

  typedef struct packed {
    logic [31:0] npc;
    logic        exc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        bv, ev, ack;
  logic [31:0] bt, evec;
  logic        flush, stall, nv, exc, af;
  logic [31:0] npc;

  logic        b_rst, b_bv, b_ev, b_ack;
  logic [31:0] b_bt, b_evec;
  logic        b_flush, b_stall, b_nv, b_exc, b_af;
  logic [31:0] b_npc;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  pippo_redirect_ctrl #(.FLUSH_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .npc_branch_valid(bv), .npc_branch(bt),
    .except_valid(ev), .except_vector(evec),
    .npc_ack(ack),
    .flush_pipe(flush), .stall_exe(stall), .npc_valid(nv), .npc(npc),
    .redirect_is_exc(exc), .align_fault(af)
  );

  pippo_redirect_ctrl #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(b_rst),
    .npc_branch_valid(b_bv), .npc_branch(b_bt),
    .except_valid(b_ev), .except_vector(b_evec),
    .npc_ack(b_ack),
    .flush_pipe(b_flush), .stall_exe(b_stall), .npc_valid(b_nv), .npc(b_npc),
    .redirect_is_exc(b_exc), .align_fault(b_af)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for npc_valid, then score npc/exc against the queue head.
  task automatic wait_npc(input string tag, input int max_cyc);
    int   n;
    exp_t e;
    n = 0;
    while (nv !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    chk({tag, "_npc_valid"}, 32'(nv), 32'd1);
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_npc"}, npc, e.npc);
      chk({tag, "_exc"}, 32'(exc), 32'(e.exc));
    end
  endtask

  task automatic ack_one();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; bv = 1'b0; ev = 1'b0; ack = 1'b0; bt = '0; evec = '0;
    b_rst = 1'b1; b_bv = 1'b0; b_ev = 1'b0; b_ack = 1'b0; b_bt = '0; b_evec = '0;
    tick(); tick();
    rst = 1'b0; b_rst = 1'b0;
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_nv", 32'(nv), 32'd0);
    chk("rst_npc", npc, 32'd0);
    chk("rst_exc", 32'(exc), 32'd0);
    chk("rst_af", 32'(af), 32'd0);

    // Basic branch: flush in cycle 1, npc in cycle 2, held until ack at 5.
    bv = 1'b1; bt = 32'h0000_1000;
    e = '{npc: 32'h1000, exc: 1'b0}; q.push_back(e);
    tick();
    bv = 1'b0;
    chk("br_flush_c1", 32'(flush), 32'd1);
    chk("br_stall_c1", 32'(stall), 32'd1);
    chk("br_nv_c1", 32'(nv), 32'd0);
    tick();
    chk("br_flush_c2", 32'(flush), 32'd0);
    wait_npc("br", 0);
    tick(); chk("br_hold_c3", npc, 32'h1000);
    tick(); chk("br_hold_c4", 32'(nv), 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("br_hold_c5", npc, 32'h1000);
    tick();
    chk("br_idle_nv", 32'(nv), 32'd0);
    chk("br_idle_stall", 32'(stall), 32'd0);

    // Simultaneous exception and branch: exception wins, branch never appears.
    ev = 1'b1; evec = 32'h0000_0100; bv = 1'b1; bt = 32'h0000_2000;
    e = '{npc: 32'h100, exc: 1'b1}; q.push_back(e);
    tick();
    ev = 1'b0; bv = 1'b0;
    wait_npc("simul", 4);
    ack_one();
    tick(); tick(); tick();
    chk("simul_no_branch_nv", 32'(nv), 32'd0);
    chk("simul_idle_stall", 32'(stall), 32'd0);

    // Exception arrives during REQ; ack delayed 3 cycles.
    bv = 1'b1; bt = 32'h0000_3000;
    e = '{npc: 32'h3000, exc: 1'b0}; q.push_back(e);
    tick();
    bv = 1'b0;
    wait_npc("pend_a", 4);
    ev = 1'b1; evec = 32'h0000_0200;
    e = '{npc: 32'h200, exc: 1'b1}; q.push_back(e);
    tick();
    ev = 1'b0;
    chk("pend_hold1", npc, 32'h3000);
    chk("pend_hold1_exc", 32'(exc), 32'd0);
    tick();
    chk("pend_hold2", npc, 32'h3000);
    ack_one();
    chk("pend_flush", 32'(flush), 32'd1);
    chk("pend_flush_nv", 32'(nv), 32'd0);
    wait_npc("pend_b", 4);
    ack_one();

    // Latest pending wins; exception in ack cycle overrides the pending one.
    bv = 1'b1; bt = 32'h0000_0A00;
    e = '{npc: 32'hA00, exc: 1'b0}; q.push_back(e);
    tick();
    bv = 1'b0;
    wait_npc("late_a", 4);
    ev = 1'b1; evec = 32'h0000_0300;
    tick();
    evec = 32'h0000_0400; ack = 1'b1;
    e = '{npc: 32'h400, exc: 1'b1}; q.push_back(e);
    tick();
    ev = 1'b0; ack = 1'b0;
    wait_npc("late_b", 4);
    ack_one();
    tick(); tick();
    chk("late_no_stale_nv", 32'(nv), 32'd0);

    // Exception during FLUSH replaces the target and restarts the flush.
    bv = 1'b1; bt = 32'h0000_5000;
    tick();
    bv = 1'b0;
    ev = 1'b1; evec = 32'h0000_0600;
    e = '{npc: 32'h600, exc: 1'b1}; q.push_back(e);
    tick();
    ev = 1'b0;
    chk("fl_exc_reload", 32'(flush), 32'd1);
    wait_npc("fl_exc", 4);
    ack_one();
    tick();

    // Reset while in REQ, then a normal branch.
    bv = 1'b1; bt = 32'h0000_7000;
    e = '{npc: 32'h7000, exc: 1'b0}; q.push_back(e);
    tick();
    bv = 1'b0;
    wait_npc("rreq_a", 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rreq_nv", 32'(nv), 32'd0);
    chk("rreq_npc", npc, 32'd0);
    chk("rreq_stall", 32'(stall), 32'd0);
    chk("rreq_flush", 32'(flush), 32'd0);
    bv = 1'b1; bt = 32'h0000_7100;
    e = '{npc: 32'h7100, exc: 1'b0}; q.push_back(e);
    tick();
    bv = 1'b0;
    wait_npc("rreq_b", 4);
    ack_one();
    tick();

    // Misaligned branch target.
    bv = 1'b1; bt = 32'h0000_1002;
`ifdef PIPPO_REDIRECT_ALIGN_CHK_EN
    e = '{npc: 32'h10, exc: 1'b1};
`else
    e = '{npc: 32'h1002, exc: 1'b0};
`endif
    q.push_back(e);
    tick();
    bv = 1'b0;
`ifdef PIPPO_REDIRECT_ALIGN_CHK_EN
    chk("align_fault_pulse", 32'(af), 32'd1);
`else
    chk("align_fault_pulse", 32'(af), 32'd0);
`endif
    chk("align_flush", 32'(flush), 32'd1);
    tick();
    chk("align_fault_drop", 32'(af), 32'd0);
    wait_npc("align", 4);
    ack_one();

    // FLUSH_CYCLES=3 instance: three flush cycles, wrong-path branches ignored.
    b_bv = 1'b1; b_bt = 32'h0000_8000;
    tick();
    b_bt = 32'h0000_9000;
    chk("fc3_flush_c1", 32'(b_flush), 32'd1);
    tick();
    chk("fc3_flush_c2", 32'(b_flush), 32'd1);
    tick();
    b_bv = 1'b0;
    chk("fc3_flush_c3", 32'(b_flush), 32'd1);
    chk("fc3_nv_c3", 32'(b_nv), 32'd0);
    tick();
    chk("fc3_flush_c4", 32'(b_flush), 32'd0);
    chk("fc3_nv_c4", 32'(b_nv), 32'd1);
    chk("fc3_npc", b_npc, 32'h8000);
    chk("fc3_exc", 32'(b_exc), 32'd0);
    b_bv = 1'b1;
    tick();
    b_bv = 1'b0;
    chk("fc3_req_hold", b_npc, 32'h8000);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    chk("fc3_idle_nv", 32'(b_nv), 32'd0);
    chk("fc3_idle_stall", 32'(b_stall), 32'd0);
    tick(); tick();
    chk("fc3_no_branch_flush", 32'(b_flush), 32'd0);
    chk("fc3_no_branch_nv", 32'(b_nv), 32'd0);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pippo_redirect_ctrl.md
Name: pippo_redirect_ctrl

Overview:
- Sequences every program-flow redirect in the pippo core.
- Takes taken-branch requests from the BPU (npc_branch_valid/npc_branch) and exception requests from the exception logic, with exceptions at higher priority.
- Drives a timed IF/ID/EXE flush, then presents the new fetch address to the fetch unit under a valid/ack handshake.
- Stalls EXE while a redirect is in flight and buffers one pending exception.

Parameters:
- FLUSH_CYCLES, 1, number of cycles flush_pipe stays high per redirect (1..7).
- RST_VECTOR, 32'h0000_0000, reserved reset fetch address; not driven on npc.
- ALIGN_VECTOR, 32'h0000_0010, exception target used for misaligned branch targets (optional feature).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- npc_branch_valid  in  1  BPU: taken branch in EXE this cycle
- npc_branch  in  32  BPU branch target
- except_valid  in  1  exception request, single-cycle pulse
- except_vector  in  32  exception handler address
- npc_ack  in  1  fetch unit accepted npc this cycle
- flush_pipe  out  1  flush IF/ID/EXE
- stall_exe  out  1  block EXE issue while a redirect is in flight
- npc_valid  out  1  redirect address valid to fetch
- npc  out  32  redirect fetch address
- redirect_is_exc  out  1  current redirect came from an exception
- align_fault  out  1  one-cycle pulse on a misaligned branch (optional feature; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0; npc=0; state=IDLE; pending slot empty; flush counter 0.
- Reset mid-operation: abandons any redirect and drops npc_valid in the cycle after rst is sampled; no ack is required.
- States: IDLE, FLUSH, REQ.
- IDLE, request capture:
  - If except_valid: capture except_vector and set exc flag=1.
  - Else if npc_branch_valid: capture npc_branch and set exc flag=0.
  - Either case: go to FLUSH and load the counter with FLUSH_CYCLES.
  - Both inputs high in the same cycle: the exception wins and the branch is dropped (it is flushed).
- FLUSH: flush_pipe=1 and stall_exe=1; counter decrements each cycle; go to REQ when the counter reaches 1.
- Latency: the request sampled in cycle N gives flush_pipe high from N+1 to N+FLUSH_CYCLES, and npc_valid first high in N+FLUSH_CYCLES+1.
- REQ:
  - npc_valid=1 and stall_exe=1; npc and redirect_is_exc are held stable until npc_ack.
  - On npc_ack: go to IDLE, or to FLUSH if the pending slot is full.
  - npc_ack outside REQ is ignored.
- Requests while busy (FLUSH or REQ):
  - npc_branch_valid is ignored, because it comes from a wrong-path instruction.
  - except_valid is written into the single pending slot. A later exception overwrites an earlier pending one (latest wins).
  - A pending exception, or one arriving in the same cycle as npc_ack, is taken on the ack cycle: load target, load the counter, go to FLUSH.
  - In FLUSH, an exception replaces the captured target directly, sets the exc flag and reloads the counter; the pending slot is not used.
- stall_exe=0 only in IDLE. In IDLE no output is combinationally dependent on the inputs; every output is registered.
- Target arithmetic: pass-through 32-bit; no modification.

Optional Feature:
- Macro: PIPPO_REDIRECT_ALIGN_CHK_EN.
- Defined:
  - On branch capture with npc_branch[1:0]!=0, replace the target with ALIGN_VECTOR and set the exc flag=1.
  - Pulse align_fault for 1 cycle, aligned with the first flush_pipe cycle.
  - An exception in the same cycle still wins and suppresses align_fault.
- Undefined: no check; align_fault is tied to 0.

Decomposition:
- Shared def_pippo.v additions: state encodings REDIR_IDLE/REDIR_FLUSH/REDIR_REQ (2 bits), REDIR_CNT_W=3, default ALIGN_VECTOR constant.
- One natural sub-module: pippo_redirect_pend, the pending-exception slot (valid + 32-bit vector, write/consume/overwrite).

Test Plan:
- Branch, FLUSH_CYCLES=1: npc_branch_valid with npc_branch=32'h0000_1000 at cycle 0 -> flush_pipe at cycle 1, npc_valid with npc=32'h1000 at cycle 2, held until npc_ack at cycle 5, IDLE at cycle 6.
- Simultaneous requests: except_valid (vector 32'h0000_0100) and branch (32'h2000) in the same cycle -> npc=32'h100, redirect_is_exc=1; the branch never appears.
- Exception while waiting: exception 32'h200 during REQ for branch 32'h3000 with npc_ack delayed 3 cycles -> npc stays 32'h3000 until ack, then flush, then npc=32'h200 with redirect_is_exc=1.
- Ignored branches and FLUSH_CYCLES=3: branch pulses during FLUSH/REQ are ignored; flush_pipe lasts exactly 3 cycles.
- Reset in REQ: rst asserted while npc_valid=1 -> next cycle all outputs 0 and state IDLE; a branch after rst deasserts is handled normally.
- Alignment check (PIPPO_REDIRECT_ALIGN_CHK_EN defined): branch to 32'h1002 -> npc=32'h10, redirect_is_exc=1, align_fault 1-cycle pulse. Macro undefined -> npc=32'h1002.
